// File: rtl/iomem_gpio.sv
// GPIO peripheral for the picosoc iomem bus.
// Per-pin data/direction registers, atomic set/clear/toggle, synchronised
// inputs and per-pin rise/fall edge interrupts with write-1-to-clear status.
module iomem_gpio #(
    parameter int          NUM_PINS    = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    localparam logic [3:0] REG_DATA_OUT = 4'd0;
    localparam logic [3:0] REG_DIR      = 4'd1;
    localparam logic [3:0] REG_DATA_IN  = 4'd2;
    localparam logic [3:0] REG_SET      = 4'd3;
    localparam logic [3:0] REG_CLR      = 4'd4;
    localparam logic [3:0] REG_TGL      = 4'd5;
    localparam logic [3:0] REG_RISE_EN  = 4'd6;
    localparam logic [3:0] REG_FALL_EN  = 4'd7;
    localparam logic [3:0] REG_STATUS   = 4'd8;

    logic [NUM_PINS-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_in;
    logic [NUM_PINS-1:0] prev_in_reg;

    logic [NUM_PINS-1:0] data_out_reg, data_out_next;
    logic [NUM_PINS-1:0] dir_reg, dir_next;
    logic [NUM_PINS-1:0] rise_en_reg, rise_en_next;
    logic [NUM_PINS-1:0] fall_en_reg, fall_en_next;
    logic [NUM_PINS-1:0] irq_status_reg, irq_status_next;
    logic [NUM_PINS-1:0] w1c_bits;
    logic [NUM_PINS-1:0] edge_evt;

    logic                iomem_ready_reg;
    logic [31:0]         iomem_rdata_reg;
    logic [31:0]         rdata_next;

    logic [31:0]         byte_mask;
    logic [31:0]         wdata_masked;
    logic [NUM_PINS-1:0] wbits;
    logic [NUM_PINS-1:0] wmask;
    logic [3:0]          reg_idx;
    logic                sel;
    logic                wr;
    logic                unused_bits;

    // Expand byte strobes into a 32-bit lane mask.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_mask[8*gi +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    assign wdata_masked = iomem_wdata & byte_mask;
    assign wbits        = wdata_masked[NUM_PINS-1:0];
    assign wmask        = byte_mask[NUM_PINS-1:0];
    assign reg_idx      = iomem_addr[5:2];

    // Accept a request only when addressed and not already acknowledging,
    // which limits back-to-back acks to every other cycle.
    assign sel = iomem_valid && !iomem_ready_reg && (iomem_addr[31:24] == BASE_ADDR);
    assign wr  = sel && (iomem_wstrb != 4'b0000);

    // Address bits outside the decode and write bits above the pin count.
    assign unused_bits = ^{iomem_addr[23:6], iomem_addr[1:0], wdata_masked, byte_mask};

    // Input synchroniser chain: stage 0 samples the pads, each later stage the one before.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= gpio_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign sync_in  = sync_reg[SYNC_STAGES-1];
    assign edge_evt = (sync_in & ~prev_in_reg & rise_en_reg)
                    | (~sync_in & prev_in_reg & fall_en_reg);

    // Register read mux; write-only and unmapped slots read zero.
    always_comb begin
        rdata_next = '0;
        case (reg_idx)
            REG_DATA_OUT: rdata_next = 32'(data_out_reg);
            REG_DIR:      rdata_next = 32'(dir_reg);
            REG_DATA_IN:  rdata_next = 32'(sync_in);
            REG_RISE_EN:  rdata_next = 32'(rise_en_reg);
            REG_FALL_EN:  rdata_next = 32'(fall_en_reg);
            REG_STATUS:   rdata_next = 32'(irq_status_reg);
            default:      rdata_next = '0;
        endcase
    end

    // Register update; an edge event on a bit wins over a W1C on that bit.
    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        rise_en_next  = rise_en_reg;
        fall_en_next  = fall_en_reg;
        w1c_bits      = '0;
        if (wr) begin
            case (reg_idx)
                REG_DATA_OUT: data_out_next = (data_out_reg & ~wmask) | wbits;
                REG_DIR:      dir_next      = (dir_reg & ~wmask) | wbits;
                REG_SET:      data_out_next = data_out_reg | wbits;
                REG_CLR:      data_out_next = data_out_reg & ~wbits;
                REG_TGL:      data_out_next = data_out_reg ^ wbits;
                REG_RISE_EN:  rise_en_next  = (rise_en_reg & ~wmask) | wbits;
                REG_FALL_EN:  fall_en_next  = (fall_en_reg & ~wmask) | wbits;
                REG_STATUS:   w1c_bits      = wbits;
                default:      ;
            endcase
        end
        irq_status_next = (irq_status_reg & ~w1c_bits) | edge_evt;
    end

    // State registers, bus acknowledge and read-data capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_in_reg     <= '0;
            data_out_reg    <= '0;
            dir_reg         <= '0;
            rise_en_reg     <= '0;
            fall_en_reg     <= '0;
            irq_status_reg  <= '0;
            iomem_ready_reg <= 1'b0;
            iomem_rdata_reg <= '0;
        end else begin
            prev_in_reg     <= sync_in;
            data_out_reg    <= data_out_next;
            dir_reg         <= dir_next;
            rise_en_reg     <= rise_en_next;
            fall_en_reg     <= fall_en_next;
            irq_status_reg  <= irq_status_next;
            iomem_ready_reg <= sel;
            if (sel) begin
                iomem_rdata_reg <= rdata_next;
            end
        end
    end

    assign iomem_ready = iomem_ready_reg;
    assign iomem_rdata = iomem_rdata_reg;
    assign gpio_out    = data_out_reg;
    assign gpio_oe     = dir_reg;
    assign irq         = |irq_status_reg;

endmodule

// File: tb/tb_iomem_gpio.sv
// Self-checking bench for iomem_gpio: vector table, edge/W1C sequences,
// reset corner cases and a randomized phase against a register-level model.
module tb_iomem_gpio;

    localparam int NP   = 8;
    localparam int SYNC = 2;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] PIN_MASK = 32'h0000_00FF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [NP-1:0] gpio_in;
    logic [NP-1:0] gpio_out;
    logic [NP-1:0] gpio_oe;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    iomem_gpio #(.NUM_PINS(NP), .BASE_ADDR(8'h03), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transfer; returns ready at the ack edge and one cycle later.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic r1, output logic r2, output logic [31:0] rd,
                       output logic irq_a);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(posedge clk);
        #1;
        r1    = iomem_ready;
        rd    = iomem_rdata;
        irq_a = irq;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        r2 = iomem_ready;
    endtask

    // Transfer plus handshake and read-data checks; returns irq seen at the ack.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, output logic irq_a);
        logic r1, r2;
        logic [31:0] rd;
        bus(a, s, d, r1, r2, rd, irq_a);
        chk({tag, " ready"}, {31'd0, r1}, 32'd1);
        chk({tag, " ready_drop"}, {31'd0, r2}, 32'd0);
        chk({tag, " rdata"}, rd, exp_rd);
        $display("xfer %s addr=%h strb=%b wdata=%h rdata=%h", tag, a, s, d, rd);
    endtask

    // Register-level reference model.
    logic [31:0] m_out, m_dir, m_rise, m_fall, m_stat, m_in;

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++)
            if (s[k]) m[8*k +: 8] = 8'hFF;
        return m & PIN_MASK;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return m_out;
            1: return m_dir;
            2: return m_in;
            6: return m_rise;
            7: return m_fall;
            8: return m_stat;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input int idx, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] pm, m;
        pm = lane_mask(s);
        m  = d & pm;
        case (idx)
            0: m_out  = (m_out & ~pm) | m;
            1: m_dir  = (m_dir & ~pm) | m;
            3: m_out  = m_out | m;
            4: m_out  = m_out & ~m;
            5: m_out  = m_out ^ m;
            6: m_rise = (m_rise & ~pm) | m;
            7: m_fall = (m_fall & ~pm) | m;
            8: m_stat = m_stat & ~m;
            default: ;
        endcase
    endtask

    initial begin
        logic ia;
        logic seen;
        int   lat;
        int   idx;
        logic [3:0]  s;
        logic [31:0] d, nin;

        resetn = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = '0;
        iomem_wdata = '0;
        gpio_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset gpio_out", 32'(gpio_out), 32'd0);
        chk("reset gpio_oe", 32'(gpio_oe), 32'd0);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset ready", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Vector table: reads of every register after reset, then data-path writes.
        for (int i = 0; i < 9; i++)
            vecs[i] = '{BASE | 32'(4 * i), 4'b0000, 32'd0, 32'd0, 8'h00, 8'h00};
        vecs[9]  = '{BASE | 32'h00, 4'b0001, 32'h0000_00A5, 32'h00, 8'hA5, 8'h00};
        vecs[10] = '{BASE | 32'h0C, 4'b0001, 32'h0000_000F, 32'h00, 8'hAF, 8'h00};
        vecs[11] = '{BASE | 32'h10, 4'b0001, 32'h0000_0081, 32'h00, 8'h2E, 8'h00};
        vecs[12] = '{BASE | 32'h14, 4'b0001, 32'h0000_00FF, 32'h00, 8'hD1, 8'h00};
        vecs[13] = '{BASE | 32'h00, 4'b0010, 32'h1234_5678, 32'hD1, 8'hD1, 8'h00};
        vecs[14] = '{BASE | 32'h00, 4'b0000, 32'h0, 32'hD1, 8'hD1, 8'h00};
        vecs[15] = '{BASE | 32'h04, 4'b1111, 32'hFFFF_FFFF, 32'h00, 8'hD1, 8'hFF};
        vecs[16] = '{BASE | 32'h04, 4'b0000, 32'h0, 32'hFF, 8'hD1, 8'hFF};
        vecs[17] = '{BASE | 32'h24, 4'b0000, 32'h0, 32'h00, 8'hD1, 8'hFF};
        vecs[18] = '{BASE | 32'h24, 4'b1111, 32'hFFFF_FFFF, 32'h00, 8'hD1, 8'hFF};

        for (int i = 0; i < 19; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].strb, vecs[i].wdata,
                 vecs[i].exp_rd, ia);
            chk($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            chk($sformatf("vec%0d irq", i), {31'd0, irq}, 32'd0);
        end

        // Foreign address: never acknowledged, no state change.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'h0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (iomem_ready) seen = 1'b1;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        chk("nomatch ready", {31'd0, seen}, 32'd0);
        chk("nomatch gpio_out", 32'(gpio_out), 32'hD1);

        // Edge interrupts: pin 1 high before falls are enabled, then enable.
        @(negedge clk);
        gpio_in = 8'h02;
        repeat (SYNC + 3) @(posedge clk);
        xfer("rise_en", BASE | 32'h18, 4'b0001, 32'h01, 32'h00, ia);
        xfer("fall_en", BASE | 32'h1C, 4'b0001, 32'h02, 32'h00, ia);
        xfer("status0", BASE | 32'h20, 4'b0000, 32'h0, 32'h00, ia);

        @(negedge clk);
        gpio_in = 8'h03;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (irq && lat == 0) lat = i;
        end
        chk("rise latency", 32'(lat), 32'(SYNC + 1));
        xfer("status rise", BASE | 32'h20, 4'b0000, 32'h0, 32'h01, ia);

        @(negedge clk);
        gpio_in = 8'h01;
        repeat (SYNC + 2) @(posedge clk);
        xfer("status fall", BASE | 32'h20, 4'b0000, 32'h0, 32'h03, ia);

        @(negedge clk);
        gpio_in = 8'h05;
        repeat (SYNC + 2) @(posedge clk);
        xfer("status pin2", BASE | 32'h20, 4'b0000, 32'h0, 32'h03, ia);
        xfer("data_in", BASE | 32'h08, 4'b0000, 32'h0, 32'h05, ia);

        xfer("w1c all", BASE | 32'h20, 4'b0001, 32'h03, 32'h03, ia);
        chk("w1c all irq", {31'd0, ia}, 32'd0);
        xfer("status clr", BASE | 32'h20, 4'b0000, 32'h0, 32'h00, ia);

        // Pin 0 fall is not enabled; a later rise sets status bit 0 again.
        @(negedge clk);
        gpio_in = 8'h04;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (SYNC + 2) @(posedge clk);
        xfer("status re-rise", BASE | 32'h20, 4'b0000, 32'h0, 32'h01, ia);

        // W1C lands on the same edge as a freshly detected rise: set wins.
        @(negedge clk);
        gpio_in = 8'h04;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (SYNC) @(posedge clk);
        xfer("w1c collide", BASE | 32'h20, 4'b0001, 32'h01, 32'h01, ia);
        chk("collide irq", {31'd0, ia}, 32'd1);
        xfer("status collide", BASE | 32'h20, 4'b0000, 32'h0, 32'h01, ia);
        xfer("w1c plain", BASE | 32'h20, 4'b0001, 32'h01, 32'h01, ia);
        chk("plain irq", {31'd0, ia}, 32'd0);

        // Status survives disabling the enables.
        @(negedge clk);
        gpio_in = 8'h04;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (SYNC + 2) @(posedge clk);
        xfer("rise_en off", BASE | 32'h18, 4'b0001, 32'h00, 32'h01, ia);
        xfer("status kept", BASE | 32'h20, 4'b0000, 32'h0, 32'h01, ia);

        // Reset asserted together with a request: no ack, everything cleared.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wstrb = 4'b0000;
        resetn      = 1'b0;
        gpio_in     = '0;
        @(posedge clk);
        #1;
        chk("rst ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst gpio_out", 32'(gpio_out), 32'd0);
        chk("rst gpio_oe", 32'(gpio_oe), 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        iomem_valid = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        xfer("post-rst read", BASE | 32'h00, 4'b0000, 32'h0, 32'h00, ia);
        xfer("post-rst status", BASE | 32'h20, 4'b0000, 32'h0, 32'h00, ia);

        // Randomized phase against the model.
        m_out = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_in = 0;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                nin = 32'($urandom) & PIN_MASK;
                @(negedge clk);
                gpio_in = nin[NP-1:0];
                repeat (SYNC + 2) @(posedge clk);
                m_stat = m_stat | ((nin & ~m_in) & m_rise) | ((~nin & m_in) & m_fall);
                m_in = nin;
            end
            idx = $urandom_range(0, 10);
            s   = 4'($urandom);
            d   = 32'($urandom);
            xfer($sformatf("rand%0d r%0d", it, idx), BASE | 32'(4 * idx), s, d,
                 model_read(idx), ia);
            model_write(idx, s, d);
            chk("rand gpio_out", 32'(gpio_out), m_out);
            chk("rand gpio_oe", 32'(gpio_oe), m_dir);
            chk("rand irq", {31'd0, irq}, {31'd0, |m_stat});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
